// File: rtl/uart_reg_responder.sv
// UART command responder: decodes 'W' addr data / 'R' addr byte streams from an RX FIFO,
// drives a simple register port and pushes a one-byte reply into the TX FIFO.
module uart_reg_responder #(
  parameter int unsigned Data_width     = 8,
  parameter int unsigned Num_regs       = 16,
  parameter int unsigned Timeout_cycles = 65535,
  parameter int unsigned tmo_width      = 16
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  rx_empty,
  input  logic [Data_width-1:0] r_data,
  output logic                  rd_uart,
  input  logic                  tx_full,
  output logic                  wr_uart,
  output logic [Data_width-1:0] w_data,
  output logic                  reg_wr,
  output logic                  reg_rd,
  output logic [Data_width-1:0] reg_addr,
  output logic [Data_width-1:0] reg_wdata,
  input  logic [Data_width-1:0] reg_rdata,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StGetAddr   = 3'd1;
  localparam logic [2:0] StGetData   = 3'd2;
  localparam logic [2:0] StRegWrite  = 3'd3;
  localparam logic [2:0] StRegRead   = 3'd4;
  localparam logic [2:0] StReadWait  = 3'd5;
  localparam logic [2:0] StSend      = 3'd6;

  localparam logic [Data_width-1:0] CmdWrite = Data_width'(8'h57);
  localparam logic [Data_width-1:0] CmdRead  = Data_width'(8'h52);
  localparam logic [Data_width-1:0] RspAck   = Data_width'(8'h4B);
  localparam logic [Data_width-1:0] RspNak   = Data_width'(8'h3F);
  localparam logic [tmo_width-1:0]  TmoLast  = tmo_width'(Timeout_cycles - 1);

  logic [2:0]            state_q, state_d;
  logic [Data_width-1:0] addr_q, addr_d;
  logic [Data_width-1:0] wdata_q, wdata_d;
  logic [Data_width-1:0] reply_q, reply_d;
  logic                  is_wr_q, is_wr_d;
  logic [tmo_width-1:0]  tmo_q, tmo_d;
  logic [7:0]            err_q, err_d;
  logic                  run_q;
  logic                  err_inc;

  function automatic logic addr_ok(input logic [Data_width-1:0] a);
    return 32'(a) < Num_regs;
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    reply_d = reply_q;
    is_wr_d = is_wr_q;
    tmo_d   = tmo_q;
    err_inc = 1'b0;
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    reg_wr  = 1'b0;
    reg_rd  = 1'b0;
    case (state_q)
      StIdle: begin
        // run_q holds off the first pop until one full cycle after reset release
        if (run_q && !rx_empty) begin
          rd_uart = 1'b1;
          if (r_data == CmdWrite || r_data == CmdRead) begin
            is_wr_d = (r_data == CmdWrite);
            tmo_d   = '0;
            state_d = StGetAddr;
          end else begin
            reply_d = RspNak;
            err_inc = 1'b1;
            state_d = StSend;
          end
        end
      end
      StGetAddr: begin
        if (!rx_empty) begin
          rd_uart = 1'b1;
          addr_d  = r_data;
          if (is_wr_q) begin
            tmo_d   = '0;
            state_d = StGetData;
          end else if (addr_ok(r_data)) begin
            state_d = StRegRead;
          end else begin
            reply_d = RspNak;
            err_inc = 1'b1;
            state_d = StSend;
          end
        end else if (tmo_q == TmoLast) begin
          err_inc = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StGetData: begin
        if (!rx_empty) begin
          rd_uart = 1'b1;
          wdata_d = r_data;
          if (addr_ok(addr_q)) begin
            state_d = StRegWrite;
          end else begin
            reply_d = RspNak;
            err_inc = 1'b1;
            state_d = StSend;
          end
        end else if (tmo_q == TmoLast) begin
          err_inc = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StRegWrite: begin
        reg_wr  = 1'b1;
        reply_d = RspAck;
        state_d = StSend;
      end
      StRegRead: begin
        reg_rd  = 1'b1;
        state_d = StReadWait;
      end
      StReadWait: begin
        reply_d = reg_rdata;
        state_d = StSend;
      end
      StSend: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (err_inc && err_q != 8'hFF) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      reply_q <= '0;
      is_wr_q <= 1'b0;
      tmo_q   <= '0;
      err_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      reply_q <= reply_d;
      is_wr_q <= is_wr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

  assign w_data    = reply_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = (state_q != StIdle);
  assign err_count = err_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Bench for uart_reg_responder: FIFO/register-file environment plus a command-level
// reference model that predicts reply, register access and error count per command.
module tb_uart_reg_responder;

  localparam int unsigned Tmo = 100;

  logic       clk = 1'b0;
  logic       Reset, rx_empty, tx_full, rd_uart, wr_uart, reg_wr, reg_rd, busy;
  logic [7:0] r_data, w_data, reg_addr, reg_wdata, reg_rdata, err_count;

  always #5 clk = ~clk;

  uart_reg_responder #(
    .Data_width    (8),
    .Num_regs      (16),
    .Timeout_cycles(Tmo),
    .tmo_width     (16)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .reg_wr   (reg_wr),
    .reg_rd   (reg_rd),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .busy     (busy),
    .err_count(err_count)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] rxq[$];
  int         cyc = 0;
  int         pop_cyc[$];
  int         push_cyc[$];
  logic [7:0] push_dat[$];
  logic [7:0] wr_addr_log[$];
  logic [7:0] wr_dat_log[$];
  logic [7:0] rd_addr_log[$];
  int         viol = 0;
  logic [7:0] env_regs[256];
  logic [7:0] model_regs[16];
  int         model_err = 0;
  bit         env_pop, env_rd;
  logic [7:0] env_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Environment: RX FIFO, register file and output monitor. Samples mid-cycle,
  // updates inputs just after the rising edge.
  initial begin
    rx_empty  = 1'b1;
    r_data    = 8'h00;
    reg_rdata = 8'h00;
    for (int i = 0; i < 256; i++) env_regs[i] = 8'(i * 27 + 9);
    forever begin
      @(negedge clk);
      cyc++;
      env_pop = 1'b0;
      if (rd_uart === 1'b1) begin
        if (rx_empty) viol++;
        pop_cyc.push_back(cyc);
        env_pop = 1'b1;
      end
      if (wr_uart === 1'b1) begin
        if (tx_full) viol++;
        push_cyc.push_back(cyc);
        push_dat.push_back(w_data);
      end
      if (reg_wr === 1'b1) begin
        wr_addr_log.push_back(reg_addr);
        wr_dat_log.push_back(reg_wdata);
        env_regs[reg_addr] = reg_wdata;
      end
      if (reg_rd === 1'b1) rd_addr_log.push_back(reg_addr);
      if ($countones({rd_uart === 1'b1, wr_uart === 1'b1, reg_wr === 1'b1}) > 1) viol++;
      if (rd_uart === 1'b1 && reg_rd === 1'b1) viol++;
      env_rd   = (reg_rd === 1'b1);
      env_addr = reg_addr;
      @(posedge clk);
      #1;
      if (env_pop && rxq.size() > 0) void'(rxq.pop_front());
      rx_empty  = (rxq.size() == 0);
      r_data    = rx_empty ? 8'($urandom) : rxq[0];
      reg_rdata = env_rd ? env_regs[env_addr] : 8'($urandom);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    pop_cyc.delete();
    push_cyc.delete();
    push_dat.delete();
    wr_addr_log.delete();
    wr_dat_log.delete();
    rd_addr_log.delete();
  endtask

  function automatic void bump_err();
    if (model_err < 255) model_err++;
  endfunction

  task automatic push_bytes(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(0, 3)) step();
      rxq.push_back(b[i]);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (rxq.size() == 0 && busy === 1'b0) done = 1'b1;
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // One complete command: model prediction, then compare everything the DUT did.
  task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                         input string tag);
    logic [7:0] bytes[$];
    logic [7:0] exp_reply;
    bit         exp_wr, exp_rd;
    int         nb;
    exp_wr = 1'b0;
    exp_rd = 1'b0;
    if (cmd == 8'h57) begin
      nb = 3;
      if (addr < 16) begin
        exp_wr = 1'b1;
        model_regs[addr[3:0]] = data;
        exp_reply = 8'h4B;
      end else begin
        exp_reply = 8'h3F;
        bump_err();
      end
    end else if (cmd == 8'h52) begin
      nb = 2;
      if (addr < 16) begin
        exp_rd = 1'b1;
        exp_reply = model_regs[addr[3:0]];
      end else begin
        exp_reply = 8'h3F;
        bump_err();
      end
    end else begin
      nb = 1;
      exp_reply = 8'h3F;
      bump_err();
    end
    bytes = {cmd, addr, data};
    while (bytes.size() > nb) void'(bytes.pop_back());
    clear_logs();
    push_bytes(bytes);
    wait_idle(100, tag);
    check_eq({tag, "_pops"}, 32'(pop_cyc.size()), 32'(nb));
    check_eq({tag, "_pushes"}, 32'(push_cyc.size()), 32'd1);
    if (push_dat.size() > 0) check_eq({tag, "_reply"}, 32'(push_dat[0]), 32'(exp_reply));
    check_eq({tag, "_wr_n"}, 32'(wr_addr_log.size()), 32'(exp_wr));
    if (exp_wr && wr_addr_log.size() > 0) begin
      check_eq({tag, "_wr_addr"}, 32'(wr_addr_log[0]), 32'(addr));
      check_eq({tag, "_wr_data"}, 32'(wr_dat_log[0]), 32'(data));
    end
    check_eq({tag, "_rd_n"}, 32'(rd_addr_log.size()), 32'(exp_rd));
    if (exp_rd && rd_addr_log.size() > 0)
      check_eq({tag, "_rd_addr"}, 32'(rd_addr_log[0]), 32'(addr));
    check_eq({tag, "_err"}, 32'(err_count), 32'(model_err));
    if (exp_wr && push_cyc.size() > 0 && pop_cyc.size() == 3)
      check_eq({tag, "_lat"}, 32'(push_cyc[0] - pop_cyc[2]), 32'd2);
    if (exp_rd && push_cyc.size() > 0 && pop_cyc.size() == 2)
      check_eq({tag, "_lat"}, 32'(push_cyc[0] - pop_cyc[1]), 32'd3);
  endtask

  // Partial command that stalls: expect an abort after Tmo idle cycles, nothing else.
  task automatic run_timeout(input logic [7:0] cmd, input logic [7:0] addr, input int nb,
                             input string tag);
    logic [7:0] bytes[$];
    int         waited;
    bytes = {cmd, addr};
    while (bytes.size() > nb) void'(bytes.pop_back());
    bump_err();
    clear_logs();
    push_bytes(bytes);
    wait_idle(Tmo + 50, tag);
    waited = (pop_cyc.size() > 0) ? cyc - pop_cyc[pop_cyc.size() - 1] : 0;
    check_eq({tag, "_pops"}, 32'(pop_cyc.size()), 32'(nb));
    check_eq({tag, "_window"}, 32'(waited >= Tmo && waited <= Tmo + 1), 32'd1);
    check_eq({tag, "_pushes"}, 32'(push_cyc.size()), 32'd0);
    check_eq({tag, "_acc"}, 32'(wr_addr_log.size() + rd_addr_log.size()), 32'd0);
    check_eq({tag, "_err"}, 32'(err_count), 32'(model_err));
  endtask

  initial begin
    logic [7:0] c, a;
    int         k;
    bit         seen;
    Reset   = 1'b0;
    tx_full = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'(i * 27 + 9);
    repeat (3) step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err_count), 32'd0);
    check_eq("rst_strobes", 32'({rd_uart, wr_uart, reg_wr, reg_rd}), 32'd0);
    check_eq("rst_w_data", 32'(w_data), 32'd0);
    check_eq("rst_reg_addr", 32'(reg_addr), 32'd0);
    check_eq("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    Reset = 1'b1;
    repeat (2) step();

    // Register 3 powers up as 0x5A in both the register file and the model.
    run_cmd(8'h52, 8'h03, 8'h00, "rd3");
    run_cmd(8'h57, 8'h03, 8'hA5, "wr3");
    run_cmd(8'h52, 8'h03, 8'h00, "rd3_after_wr");
    run_cmd(8'h41, 8'h00, 8'h00, "badcmd");
    run_cmd(8'h57, 8'h10, 8'h00, "badaddr_w");
    run_cmd(8'h52, 8'h20, 8'h00, "badaddr_r");
    run_cmd(8'h52, 8'h0F, 8'h00, "rd_last");
    run_timeout(8'h52, 8'h00, 1, "tmo_r");
    run_cmd(8'h52, 8'h01, 8'h00, "after_tmo");
    run_timeout(8'h57, 8'h05, 2, "tmo_w");
    run_cmd(8'h52, 8'h05, 8'h00, "after_tmo_w");

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k < 4) c = 8'h57;
      else if (k < 8) c = 8'h52;
      else begin
        c = 8'($urandom);
        while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
      end
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      run_cmd(c, a, 8'($urandom), "rand");
    end

    // Backpressure: reply held while the TX FIFO reports full.
    tx_full = 1'b1;
    clear_logs();
    push_bytes({8'h52, 8'h03});
    repeat (200) step();
    check_eq("bp_hold_push", 32'(push_cyc.size()), 32'd0);
    check_eq("bp_hold_busy", 32'(busy), 32'd1);
    tx_full = 1'b0;
    wait_idle(20, "bp");
    check_eq("bp_pushes", 32'(push_cyc.size()), 32'd1);
    if (push_dat.size() > 0) check_eq("bp_reply", 32'(push_dat[0]), 32'(model_regs[3]));

    // Saturation of the error counter.
    clear_logs();
    for (int i = 0; i < 270; i++) begin
      c = 8'($urandom);
      while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
      rxq.push_back(c);
      bump_err();
    end
    wait_idle(270 * 6, "sat");
    check_eq("sat_pushes", 32'(push_cyc.size()), 32'd270);
    check_eq("sat_err", 32'(err_count), 32'(model_err));

    // Reset in the middle of a write command.
    clear_logs();
    push_bytes({8'h57, 8'h02});
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (pop_cyc.size() == 2) seen = 1'b1;
    end
    check_eq("mid_pops", 32'(pop_cyc.size()), 32'd2);
    repeat (2) step();
    Reset = 1'b0;
    repeat (2) step();
    model_err = 0;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_err", 32'(err_count), 32'd0);
    check_eq("mid_rst_addr", 32'(reg_addr), 32'd0);
    Reset = 1'b1;
    clear_logs();
    repeat (30) step();
    check_eq("mid_no_reply", 32'(push_cyc.size()), 32'd0);
    check_eq("mid_no_acc", 32'(wr_addr_log.size() + rd_addr_log.size()), 32'd0);
    check_eq("mid_idle", 32'(busy), 32'd0);

    // Byte waiting in the FIFO across reset release.
    Reset = 1'b0;
    step();
    rxq.push_back(8'h41);
    step();
    check_eq("rst_hold_nopop", 32'(rd_uart), 32'd0);
    clear_logs();
    Reset = 1'b1;
    check_eq("rel_nopop", 32'(rd_uart), 32'd0);
    bump_err();
    wait_idle(20, "rel");
    check_eq("rel_pops", 32'(pop_cyc.size()), 32'd1);
    check_eq("rel_pushes", 32'(push_cyc.size()), 32'd1);
    if (push_dat.size() > 0) check_eq("rel_reply", 32'(push_dat[0]), 32'h3F);
    check_eq("rel_err", 32'(err_count), 32'(model_err));

    check_eq("protocol_violations", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
